// File: rtl/rr_arbiter_hold.sv
// Round-robin arbiter with bounded grant tenure.
// The grant is registered and one-hot; the owner keeps it for up to MAX_HOLD cycles.
module rr_arbiter_hold #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  parameter int IW       = $clog2(N),
  parameter int CW       = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  REQ,
  output logic [N-1:0]  GNT,
  output logic [IW-1:0] gnt_id,
  output logic          gnt_valid
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t        r_state, w_state_nx;
  logic [IW-1:0] r_ptr, w_ptr_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [N-1:0]  r_gnt, w_gnt_nx;
  logic [IW-1:0] r_id, w_id_nx;
  logic          r_valid, w_valid_nx;

  logic [IW-1:0] w_next_id;
  logic [IW-1:0] w_start;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_idx;
  logic          w_found;
  logic          w_release;

  assign w_next_id = (r_id == IW'(N - 1)) ? '0 : r_id + 1'b1;
  assign w_start   = (r_state == S_IDLE) ? r_ptr : w_next_id;
  assign w_release = !REQ[r_id] || (r_cnt == CW'(MAX_HOLD));

  // First set request at or after w_start, wrapping modulo N
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = IW'((int'(w_start) + i) % N);
      if (!w_found && REQ[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    w_gnt_nx   = r_gnt;
    w_id_nx    = r_id;
    w_valid_nx = r_valid;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nx = S_GRANT;
          w_gnt_nx   = {{(N-1){1'b0}}, 1'b1} << w_win;
          w_id_nx    = w_win;
          w_valid_nx = 1'b1;
          w_cnt_nx   = CW'(1);
        end
      end
      S_GRANT: begin
        if (!w_release) begin
          w_cnt_nx = r_cnt + 1'b1;
        end else begin
          w_ptr_nx = w_next_id;
          if (w_found) begin
            w_gnt_nx   = {{(N-1){1'b0}}, 1'b1} << w_win;
            w_id_nx    = w_win;
            w_valid_nx = 1'b1;
            w_cnt_nx   = CW'(1);
          end else begin
            w_state_nx = S_IDLE;
            w_gnt_nx   = '0;
            w_id_nx    = '0;
            w_valid_nx = 1'b0;
            w_cnt_nx   = '0;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_id    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
      r_gnt   <= w_gnt_nx;
      r_id    <= w_id_nx;
      r_valid <= w_valid_nx;
    end
  end

  assign GNT       = r_gnt;
  assign gnt_id    = r_id;
  assign gnt_valid = r_valid;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Bench for rr_arbiter_hold: MAX_HOLD=4 and MAX_HOLD=1 instances
// against a tenure-level model plus literal expectations.
module tb_rr_arbiter_hold;

  localparam int N = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req0  = '0;
  logic [N-1:0] req1  = '0;
  logic [N-1:0] gnt0, gnt1;
  logic [1:0]   id0, id1;
  logic         v0, v1;

  rr_arbiter_hold #(.N(4), .MAX_HOLD(4)) u0 (
    .clk(clk), .rst_n(rst_n), .REQ(req0),
    .GNT(gnt0), .gnt_id(id0), .gnt_valid(v0)
  );

  rr_arbiter_hold #(.N(4), .MAX_HOLD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .REQ(req1),
    .GNT(gnt1), .gnt_id(id1), .gnt_valid(v1)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // owner -1 means idle
  int m_owner[2] = '{-1, -1};
  int m_ptr[2]   = '{0, 0};
  int m_cnt[2]   = '{0, 0};
  int m_hold[2]  = '{4, 1};

  function automatic int pick(int start, logic [N-1:0] r);
    for (int i = 0; i < N; i++)
      if (r[(start + i) % N]) return (start + i) % N;
    return -1;
  endfunction

  function automatic void m_step(int k, logic [N-1:0] r);
    int w;
    if (m_owner[k] < 0) begin
      w = pick(m_ptr[k], r);
      if (w >= 0) begin
        m_owner[k] = w;
        m_cnt[k]   = 1;
      end
    end else if (r[m_owner[k]] && m_cnt[k] < m_hold[k]) begin
      m_cnt[k]++;
    end else begin
      m_ptr[k] = (m_owner[k] + 1) % N;
      w = pick(m_ptr[k], r);
      m_owner[k] = w;
      m_cnt[k]   = (w >= 0) ? 1 : 0;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_owner[k] = -1;
        m_ptr[k]   = 0;
        m_cnt[k]   = 0;
      end
    end else begin
      m_step(0, req0);
      m_step(1, req1);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [31:0] eg, ei, ev;
        eg = (m_owner[k] < 0) ? 32'd0 : (32'd1 << m_owner[k]);
        ei = (m_owner[k] < 0) ? 32'd0 : 32'(m_owner[k]);
        ev = (m_owner[k] < 0) ? 32'd0 : 32'd1;
        chk($sformatf("model_gnt_u%0d", k), k ? 32'(gnt1) : 32'(gnt0), eg);
        chk($sformatf("model_id_u%0d", k), k ? 32'(id1) : 32'(id0), ei);
        chk($sformatf("model_valid_u%0d", k), k ? 32'(v1) : 32'(v0), ev);
      end
    end
  end

  task automatic tick(logic [N-1:0] a, logic [N-1:0] b);
    @(negedge clk);
    req0 = a;
    req1 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt0), 32'd0);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_id", 32'(id0), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    for (int i = 0; i < 5; i++) begin
      tick(4'b0000, 4'b0000);
      chk("idle_gnt", 32'(gnt0), 32'd0);
      chk("idle_valid", 32'(v0), 32'd0);
      chk("idle_id", 32'(id0), 32'd0);
    end

    for (int i = 0; i < 10; i++) begin
      tick(4'b1000, 4'b0000);
      chk("solo_gnt", 32'(gnt0), 32'b1000);
      chk("solo_id", 32'(id0), 32'd3);
    end
    tick(4'b0000, 4'b0000);
    chk("solo_drop", 32'(gnt0), 32'd0);

    for (int i = 0; i < 20; i++) begin
      tick(4'b1111, 4'b0000);
      chk("all_gnt", 32'(gnt0), 32'd1 << ((i / 4) % 4));
      chk("all_id", 32'(id0), 32'((i / 4) % 4));
    end
    tick(4'b0000, 4'b0000);
    chk("all_drop", 32'(gnt0), 32'd0);
    tick(4'b1000, 4'b0000);
    chk("wrap_gnt", 32'(gnt0), 32'b1000);
    tick(4'b0000, 4'b0000);
    chk("wrap_drop", 32'(gnt0), 32'd0);

    tick(4'b0011, 4'b0000);
    chk("ho_gnt_a", 32'(gnt0), 32'b0001);
    tick(4'b0011, 4'b0000);
    chk("ho_gnt_b", 32'(gnt0), 32'b0001);
    tick(4'b0010, 4'b0000);
    chk("ho_gnt_c", 32'(gnt0), 32'b0010);
    chk("ho_valid_c", 32'(v0), 32'd1);
    tick(4'b0000, 4'b0000);
    chk("ho_drop", 32'(gnt0), 32'd0);

    tick(4'b0100, 4'b0000);
    chk("pre_rst_gnt", 32'(gnt0), 32'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt0), 32'd0);
    chk("async_id", 32'(id0), 32'd0);
    chk("async_valid", 32'(v0), 32'd0);
    @(negedge clk);
    req0  = 4'b1111;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_gnt", 32'(gnt0), 32'b0001);

    for (int i = 0; i < 8; i++) begin
      tick(4'b0000, 4'b1010);
      chk("rr1_gnt", 32'(gnt1), (i % 2) ? 32'b1000 : 32'b0010);
    end
    tick(4'b0000, 4'b0000);
    chk("rr1_drop", 32'(gnt1), 32'd0);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_hold.md
# rr_arbiter_hold

Parametrised round-robin arbiter for N requesters with bounded grant tenure. The grant is registered and one-hot. A granted requester keeps ownership while it holds its request, up to MAX_HOLD consecutive cycles. Ownership then rotates to the next requester in round-robin order. The block sits in front of shared resources such as memory ports and buses, and replaces fixed 4-way per-cycle arbitration where bursts must not be split.

## Interface
- N, default 4: number of requesters; must be ≥ 2.
- MAX_HOLD, default 4: maximum consecutive grant cycles per tenure; must be ≥ 1. MAX_HOLD = 1 gives plain per-cycle round-robin.
- IW = $clog2(N): width of the grant index (derived).
- CW = $clog2(MAX_HOLD+1): width of the tenure counter (derived).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- REQ  in  N  request vector; bit i = requester i. Sampled at the rising edge.
- GNT  out  N  registered one-hot grant; all zero when idle.
- gnt_id  out  IW  index of the granted requester; 0 when idle.
- gnt_valid  out  1  high when GNT is nonzero.

## Operation
- Internal state: `ptr` (IW bits, search start index), `cnt` (CW bits, tenure length), owner = current GNT.
- FSM has two states, IDLE and GRANT.
- Arbitration function pick(start): scan REQ at indices start, start+1, … mod N. Return the first set bit. Return none if REQ == 0.
- In IDLE at each edge:
  - If REQ == 0: stay in IDLE.
  - Otherwise: GNT ← onehot(pick(ptr)), cnt ← 1, go to GRANT.
- In GRANT with owner k, the release condition is REQ[k] == 0 or cnt == MAX_HOLD.
  - No release: cnt ← cnt+1; GNT is unchanged, regardless of other requests.
  - Release: ptr ← (k+1) mod N. Re-arbitrate in the same edge with pick((k+1) mod N).
    - If a winner exists: GNT ← onehot(winner), cnt ← 1, stay in GRANT. There is no idle bubble between owners.
    - If no winner: GNT ← 0, cnt ← 0, go to IDLE.
  - Requester k wins re-arbitration only if it is the sole requester. Its cnt then restarts at 1.
- gnt_id and gnt_valid are registered and updated in the same edge as GNT, so they are always consistent with it.
- A request arriving while another requester owns the grant waits. It does not pre-empt the owner.
- Fairness: with all N requesting continuously, each requester receives exactly MAX_HOLD cycles per N·MAX_HOLD cycles.
- GNT is never multi-hot. No X on outputs after reset, for any REQ.

## Timing
- Latency: REQ sampled at edge t → GNT valid after edge t, i.e. from cycle t+1. Latency is 1 cycle; there is no combinational path from REQ to GNT.
- Owner handover is back-to-back: the last owner cycle is followed immediately by the new owner cycle.
- Dropping REQ[k] at edge t releases the grant at that same edge. GNT[k] is low from cycle t+1.
- Reset (rst_n low), asynchronous, at any time including mid-tenure: GNT = 0, gnt_id = 0, gnt_valid = 0, ptr = 0, cnt = 0, FSM = IDLE, immediately.
- First arbitration takes place at the first rising edge after rst_n is released.
- Index wrap: after owner N-1 releases, ptr returns to 0.

## Test plan
- Reset, REQ = 0 for 5 cycles → GNT = 0, gnt_valid = 0, gnt_id = 0 throughout.
- N=4, MAX_HOLD=4, REQ = 4'b1000 held for 10 cycles → GNT = 4'b1000 continuously from the cycle after the first edge, gnt_id = 3. The tenure restarts every 4 cycles with no gap.
- N=4, MAX_HOLD=4, REQ = 4'b1111 held → GNT sequence is 0001×4, 0010×4, 0100×4, 1000×4, 0001×4. gnt_id follows 0,1,2,3,0.
- REQ = 4'b0011, grant 0001 for 2 cycles, then REQ = 4'b0010 → GNT = 0010 in the next cycle with no idle cycle. Then REQ = 0 → GNT = 0 one cycle later.
- rst_n pulsed low while GNT = 0100 → outputs 0 with no clock edge. After release with REQ = 4'b1111, the first GNT = 0001 because ptr was reset.
- N=4, MAX_HOLD=1, REQ = 4'b1010 → GNT alternates 0010, 1000, 0010, …, with each requester receiving exactly every other cycle.
